// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl: drives the s/r inputs of a NOR SR latch from single-cycle
// set/clear commands. Each command becomes a registered pulse of PULSE_W
// cycles, followed by a dead time in which s=r=0, followed by a one-cycle
// readback check of the synchronized latch outputs against the target.
module sr_drive_ctrl #(
  parameter int PULSE_W     = 4,
  parameter int GAP_W       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  input  logic cmd_set,
  output logic cmd_ready,
  output logic s,
  output logic r,
  input  logic q_fb,
  input  logic qb_fb,
  output logic exp_q,
  output logic busy,
  output logic err,
  input  logic err_clr
);

  localparam int SETTLE_W = GAP_W + SYNC_STAGES;
  localparam int CNT_MAX  = (PULSE_W > SETTLE_W) ? PULSE_W : SETTLE_W;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_PULSE  = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   tgt_q, tgt_d;
  logic                   exp_q_q, exp_q_d;
  logic                   err_q, err_d;
  logic                   s_q, r_q;
  logic [SYNC_STAGES-1:0] qs_q, qbs_q;
  logic                   q_sync, qb_sync;
  logic                   accept;
  logic                   mismatch;

  assign q_sync   = qs_q[SYNC_STAGES-1];
  assign qb_sync  = qbs_q[SYNC_STAGES-1];
  // The CHECK cycle also accepts the next command, so back-to-back
  // commands sustain one per PULSE_W+GAP_W+SYNC_STAGES+1 cycles.
  assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_CHECK);
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid & cmd_ready;
  // q_sync==qb_sync is caught because one of the two must then disagree.
  assign mismatch  = (q_sync != tgt_q) || (qb_sync != ~tgt_q);

  assign s     = s_q;
  assign r     = r_q;
  assign exp_q = exp_q_q;
  assign err   = err_q;

  // Next-state logic for the command sequencer, counter, target and flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    exp_q_d = exp_q_q;
    err_d   = err_q;
    if (err_clr) err_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        // Behaves as an accepted clear so the latch starts in a known state.
        state_d = ST_PULSE;
        tgt_d   = 1'b0;
        cnt_d   = CNT_W'(PULSE_W - 1);
      end
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_PULSE;
          tgt_d   = cmd_set;
          cnt_d   = CNT_W'(PULSE_W - 1);
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_W'(SETTLE_W - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_CHECK: begin
        exp_q_d = tgt_q;
        // A mismatch overrides a simultaneous err_clr.
        if (mismatch) err_d = 1'b1;
        if (accept) begin
          state_d = ST_PULSE;
          tgt_d   = cmd_set;
          cnt_d   = CNT_W'(PULSE_W - 1);
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state and registered latch drives; s and r are decoded from
  // the same next state with opposite target polarity, so never both high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      tgt_q   <= 1'b0;
      exp_q_q <= 1'b0;
      err_q   <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      exp_q_q <= exp_q_d;
      err_q   <= err_d;
      s_q     <= (state_d == ST_PULSE) &&  tgt_d;
      r_q     <= (state_d == ST_PULSE) && !tgt_d;
    end
  end

  // Plain flop-chain synchronizers for the asynchronous latch readback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qs_q  <= '0;
      qbs_q <= '0;
    end else begin
      qs_q  <= {qs_q[SYNC_STAGES-2:0], q_fb};
      qbs_q <= {qbs_q[SYNC_STAGES-2:0], qb_fb};
    end
  end

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Directed bench for sr_drive_ctrl with default parameters (period 9).
// A behavioural latch model closes the q/q_b loop; it can be stuck at q=0.
module tb_sr_drive_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic cmd_valid, cmd_set, cmd_ready;
  logic s, r, q_fb, qb_fb, exp_q, busy, err, err_clr;
  logic stuck;
  logic lq = 1'b1;

  int errors = 0;
  int checks = 0;

  sr_drive_ctrl #(.PULSE_W(4), .GAP_W(2), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_set(cmd_set),
    .cmd_ready(cmd_ready), .s(s), .r(r), .q_fb(q_fb), .qb_fb(qb_fb),
    .exp_q(exp_q), .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Latch model: set/reset by the drives, or clamped to q=0 when stuck.
  always @(posedge clk) begin
    if (stuck)        lq <= 1'b0;
    else if (s && !r) lq <= 1'b1;
    else if (r && !s) lq <= 1'b0;
  end
  assign q_fb  = stuck ? 1'b0 : lq;
  assign qb_fb = stuck ? 1'b1 : ~lq;

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs the 9 cycles following an accept edge: pulse cycles 1-4, dead
  // time 5-8, check cycle 9 (ready). Drives next command inputs in cycle 1
  // and err_clr in cycle 9.
  task automatic period(input string tag, input logic tgt, input logic eq1,
                        input logic ee1, input logic nv, input logic ns,
                        input logic clr9);
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 1) begin
        cmd_valid = nv;
        cmd_set   = ns;
        chk({tag, ".exp_q"}, exp_q, eq1);
        chk({tag, ".err"}, err, ee1);
      end
      chk($sformatf("%s.s%0d", tag, i), s, tgt && (i <= 4));
      chk($sformatf("%s.r%0d", tag, i), r, !tgt && (i <= 4));
      chk($sformatf("%s.rdy%0d", tag, i), cmd_ready, i == 9);
      chk($sformatf("%s.busy%0d", tag, i), busy, i != 9);
      chk($sformatf("%s.excl%0d", tag, i), s & r, 1'b0);
      if (i == 9) err_clr = clr9;
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_set = 1'b0; err_clr = 1'b0;
    stuck = 1'b0;
    #2;
    chk("rst.s", s, 1'b0);
    chk("rst.r", r, 1'b0);
    chk("rst.exp_q", exp_q, 1'b0);
    chk("rst.err", err, 1'b0);
    chk("rst.ready", cmd_ready, 1'b0);
    chk("rst.busy", busy, 1'b1);

    // Init clear with latch starting at q=1.
    @(negedge clk); rst_n = 1'b1;
    period("init", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Set then clear, back to back, valid held.
    cmd_valid = 1'b1; cmd_set = 1'b1;
    period("set", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    period("clr", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("clr.exp_q_after", exp_q, 1'b0);
    chk("clr.err_after", err, 1'b0);
    chk("idle.ready", cmd_ready, 1'b1);

    // Readback fault on a set, then err_clr.
    stuck = 1'b1;
    cmd_valid = 1'b1; cmd_set = 1'b1;
    period("fset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("fault.err", err, 1'b1);
    chk("fault.exp_q", exp_q, 1'b1);
    step();
    chk("fault.err_sticky", err, 1'b1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("fault.err_cleared", err, 1'b0);
    stuck = 1'b0;

    // Set requested while a clear is busy: taken only at the check cycle.
    cmd_valid = 1'b1; cmd_set = 1'b0;
    period("bclr", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    period("bset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("bset.exp_q", exp_q, 1'b1);
    chk("bset.err", err, 1'b0);

    // Reset during cycle 2 of a set pulse.
    cmd_valid = 1'b1; cmd_set = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("rmid.s1", s, 1'b1);
    step();
    chk("rmid.s2", s, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rmid.s_async", s, 1'b0);
    chk("rmid.r_async", r, 1'b0);
    chk("rmid.exp_q", exp_q, 1'b0);
    chk("rmid.ready", cmd_ready, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    period("rinit", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // err_clr coinciding with a mismatching check: set wins.
    stuck = 1'b1;
    cmd_valid = 1'b1; cmd_set = 1'b1;
    period("sset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    err_clr = 1'b0;
    chk("simul.err", err, 1'b1);
    chk("simul.exp_q", exp_q, 1'b1);
    stuck = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
